// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline boundary register between two stages. It carries a payload plus
//   a valid bit. Each cycle it flushes, inserts a bubble, advances or holds,
//   based on i_flush and the global stall vector. While the upstream stage is
//   stalled, it loops multi-cycle temp/count state back to that stage. It also
//   keeps saturating bubble/hold performance counters and a consecutive-hold
//   watchdog.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_stall          global stall vector (1 = stop); bit STAGE is upstream,
//                    bit STAGE+1 is downstream (absent for the last stage)
//   i_flush          exception/redirect flush, highest priority
//   i_valid, i_data  upstream instruction valid and payload
//   i_temp, i_cnt    upstream multi-cycle temp state and step count
//   i_perf_clr       synchronous clear of bubble/hold counters
//   o_valid, o_data  downstream instruction valid and payload
//   o_temp, o_cnt    multi-cycle state fed back upstream
//   o_bubble_cnt     saturating count of inserted bubbles
//   o_hold_cnt       saturating count of hold cycles
//   o_hold_run       current consecutive-hold run length (saturating)
//   o_hold_timeout   high while the hold run has reached HOLD_LIMIT
module pipe_stage_reg #(
    parameter int unsigned N_DATA         = 128,
    parameter int unsigned N_STALL        = 6,
    parameter int unsigned STAGE          = 3,
    parameter int unsigned N_TEMP         = 64,
    parameter int unsigned N_CNT          = 2,
    parameter int unsigned ZERO_ON_BUBBLE = 1,
    parameter int unsigned N_PERF         = 16,
    parameter int unsigned HOLD_LIMIT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_STALL-1:0] i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [N_DATA-1:0] i_data,
    input  logic [N_TEMP-1:0] i_temp,
    input  logic [N_CNT-1:0]  i_cnt,
    input  logic              i_perf_clr,
    output logic              o_valid,
    output logic [N_DATA-1:0] o_data,
    output logic [N_TEMP-1:0] o_temp,
    output logic [N_CNT-1:0]  o_cnt,
    output logic [N_PERF-1:0] o_bubble_cnt,
    output logic [N_PERF-1:0] o_hold_cnt,
    output logic [N_PERF-1:0] o_hold_run,
    output logic              o_hold_timeout
);

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } action_t;

    localparam logic [N_PERF-1:0] LIMIT = N_PERF'(HOLD_LIMIT);

    logic              up;
    logic              dn;
    logic              stall_unused;
    action_t           action;
    logic [N_PERF-1:0] bubble_next;
    logic [N_PERF-1:0] hold_next;
    logic [N_PERF-1:0] run_next;

    assign up = i_stall[STAGE];

    // The last stage has no downstream stall bit, so it never holds.
    generate
        if (STAGE < N_STALL - 1) begin : g_dn
            assign dn = i_stall[STAGE+1];
        end else begin : g_no_dn
            assign dn = 1'b0;
        end
    endgenerate

    // Stall bits belonging to other stage boundaries are not used here.
    assign stall_unused = ^i_stall;

    always_comb begin
        action = ACT_HOLD;
        if (i_flush) begin
            action = ACT_FLUSH;
        end else if (up && !dn) begin
            action = ACT_BUBBLE;
        end else if (!up) begin
            action = ACT_ADVANCE;
        end
    end

    always_comb begin
        bubble_next = o_bubble_cnt;
        hold_next   = o_hold_cnt;
        run_next    = '0;
        if (i_perf_clr) begin
            bubble_next = '0;
            hold_next   = '0;
        end else begin
            if (action == ACT_BUBBLE && o_bubble_cnt != '1) begin
                bubble_next = o_bubble_cnt + N_PERF'(1);
            end
            if (action == ACT_HOLD && o_hold_cnt != '1) begin
                hold_next = o_hold_cnt + N_PERF'(1);
            end
        end
        if (action == ACT_HOLD) begin
            run_next = (o_hold_run == '1) ? o_hold_run : o_hold_run + N_PERF'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_temp  <= '0;
            o_cnt   <= '0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                    o_temp  <= '0;
                    o_cnt   <= '0;
                end
                ACT_BUBBLE: begin
                    o_valid <= 1'b0;
                    if (ZERO_ON_BUBBLE != 0) begin
                        o_data <= '0;
                    end
                    o_temp <= i_temp;
                    o_cnt  <= i_cnt;
                end
                ACT_ADVANCE: begin
                    o_valid <= i_valid;
                    o_data  <= i_data;
                    o_temp  <= '0;
                    o_cnt   <= '0;
                end
                default: begin
                    o_temp <= i_temp;
                    o_cnt  <= i_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bubble_cnt   <= '0;
            o_hold_cnt     <= '0;
            o_hold_run     <= '0;
            o_hold_timeout <= 1'b0;
        end else begin
            o_bubble_cnt   <= bubble_next;
            o_hold_cnt     <= hold_next;
            o_hold_run     <= run_next;
            o_hold_timeout <= (run_next >= LIMIT);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [15:0] temp;
        logic [1:0]  cnt;
        logic [3:0]  bub;
        logic [3:0]  hold;
        logic [3:0]  run;
        logic        to;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic [15:0] temp = '0;
    logic [1:0]  cnt = '0;
    logic        clr = 1'b0;

    logic        va, vb, toa, tob;
    logic [31:0] da, db;
    logic [15:0] ta, tb_t;
    logic [1:0]  ca, cb;
    logic [3:0]  bua, bub_b, hoa, hob, rua, rub;

    int tests = 0;
    int failed = 0;

    outs_t ma, mb;
    outs_t sb_a[$];
    outs_t sb_b[$];

    always #5 clk = ~clk;

    // Instance A: middle stage, zero on bubble. Instance B: last stage, hold on bubble.
    pipe_stage_reg #(.N_DATA(32), .N_STALL(6), .STAGE(3), .N_TEMP(16), .N_CNT(2),
                     .ZERO_ON_BUBBLE(1), .N_PERF(4), .HOLD_LIMIT(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_data(data), .i_temp(temp), .i_cnt(cnt), .i_perf_clr(clr),
        .o_valid(va), .o_data(da), .o_temp(ta), .o_cnt(ca),
        .o_bubble_cnt(bua), .o_hold_cnt(hoa), .o_hold_run(rua), .o_hold_timeout(toa));

    pipe_stage_reg #(.N_DATA(32), .N_STALL(6), .STAGE(5), .N_TEMP(16), .N_CNT(2),
                     .ZERO_ON_BUBBLE(0), .N_PERF(4), .HOLD_LIMIT(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_data(data), .i_temp(temp), .i_cnt(cnt), .i_perf_clr(clr),
        .o_valid(vb), .o_data(db), .o_temp(tb_t), .o_cnt(cb),
        .o_bubble_cnt(bub_b), .o_hold_cnt(hob), .o_hold_run(rub), .o_hold_timeout(tob));

    function automatic outs_t snap_a();
        return '{va, da, ta, ca, bua, hoa, rua, toa};
    endfunction

    function automatic outs_t snap_b();
        return '{vb, db, tb_t, cb, bub_b, hob, rub, tob};
    endfunction

    function automatic outs_t model(outs_t c, int stage, bit zob);
        outs_t n;
        logic up, dn, is_bub, is_hold;
        n  = c;
        up = stall[stage];
        dn = (stage < 5) ? stall[stage+1] : 1'b0;
        is_bub  = !flush && up && !dn;
        is_hold = !flush && up && dn;
        if (flush) begin
            n.valid = 0; n.data = 0; n.temp = 0; n.cnt = 0;
        end else if (is_bub) begin
            n.valid = 0;
            if (zob) n.data = 0;
            n.temp = temp; n.cnt = cnt;
        end else if (!up) begin
            n.valid = valid; n.data = data; n.temp = 0; n.cnt = 0;
        end else begin
            n.temp = temp; n.cnt = cnt;
        end
        if (clr) begin
            n.bub = 0; n.hold = 0;
        end else begin
            if (is_bub && c.bub != 4'd15) n.bub = c.bub + 4'd1;
            if (is_hold && c.hold != 4'd15) n.hold = c.hold + 4'd1;
        end
        n.run = is_hold ? ((c.run == 4'd15) ? 4'd15 : c.run + 4'd1) : 4'd0;
        n.to  = (n.run >= 4'd3);
        return n;
    endfunction

    // Drive one cycle of stimulus, push the expected outputs, sample after the edge.
    task automatic step(input logic [5:0] s, input logic f, input logic v, input logic [31:0] d,
                        input logic [15:0] t, input logic [1:0] c, input logic cl);
        stall = s; flush = f; valid = v; data = d; temp = t; cnt = c; clr = cl;
        ma = model(ma, 3, 1'b1);
        mb = model(mb, 5, 1'b0);
        sb_a.push_back(ma);
        sb_b.push_back(mb);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = '0; flush = 0; valid = 0; data = '0; temp = '0; cnt = '0; clr = 0;
        ma = '0; mb = '0;
        sb_a.delete(); sb_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        outs_t ga, gb;
        apply_reset();
        ga = snap_a(); gb = snap_b();
        tests++;
        if (ga !== '0) begin failed++; $display("FAIL reset_a: got %h exp 0", ga); end
        tests++;
        if (gb !== '0) begin failed++; $display("FAIL reset_b: got %h exp 0", gb); end
    endtask

    task automatic test_advance_bubble();
        outs_t ea, eb, ga, gb;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            step((i == 0) ? 6'b000000 : 6'b001000, 0, 1, 32'hA5, 16'h0, 2'd0, 0);
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL adv_bub_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL adv_bub_b[%0d]: got %h exp %h", i, gb, eb); end
            if (i == 0) begin
                tests++;
                if (va !== 1'b1 || da !== 32'hA5) begin
                    failed++; $display("FAIL adv_a: got v=%b d=%h exp v=1 d=a5", va, da);
                end
            end else begin
                tests++;
                if (va !== 1'b0 || da !== 32'h0 || bua !== 4'd1) begin
                    failed++; $display("FAIL bub_a: got v=%b d=%h b=%0d exp v=0 d=0 b=1", va, da, bua);
                end
            end
        end
    endtask

    task automatic test_hold_loopback();
        outs_t ea, eb, ga, gb;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      step(6'b000000, 0, 1, 32'h11, 16'h0, 2'd0, 0);
            else if (i < 4)  step(6'b011000, 0, 0, 32'h99, 16'h1234, 2'd2, 0);
            else             step(6'b000000, 0, 0, 32'h22, 16'h0, 2'd0, 0);
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL hold_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL hold_b[%0d]: got %h exp %h", i, gb, eb); end
            if (i >= 1 && i <= 3) begin
                tests++;
                if (va !== 1'b1 || da !== 32'h11 || ta !== 16'h1234 || ca !== 2'd2 ||
                    hoa !== 4'(i) || toa !== (i == 3)) begin
                    failed++;
                    $display("FAIL hold_fix[%0d]: got v=%b d=%h t=%h c=%0d h=%0d to=%b", i, va, da, ta, ca, hoa, toa);
                end
            end
            if (i == 4) begin
                tests++;
                if (toa !== 1'b0 || rua !== 4'd0) begin
                    failed++; $display("FAIL hold_release: got to=%b run=%0d exp to=0 run=0", toa, rua);
                end
            end
        end
    endtask

    task automatic test_flush();
        outs_t ea, eb, ga, gb;
        logic [5:0] s_tab [4] = '{6'b001000, 6'b000000, 6'b001000, 6'b011000};
        logic       f_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(s_tab[i], f_tab[i], 1, 32'hFF, 16'h5555, 2'd3, 0);
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL flush_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL flush_b[%0d]: got %h exp %h", i, gb, eb); end
            if (i > 0) begin
                tests++;
                if (va !== 0 || da !== 0 || ta !== 0 || ca !== 0 || bua !== 4'd1 || hoa !== 4'd0) begin
                    failed++; $display("FAIL flush_fix[%0d]: got v=%b d=%h t=%h b=%0d h=%0d", i, va, da, ta, bua, hoa);
                end
            end
        end
    endtask

    task automatic test_saturation();
        outs_t ea, eb, ga, gb;
        apply_reset();
        for (int i = 0; i < 21; i++) begin
            step(6'b001000, 0, 1, 32'(i), 16'(i), 2'(i), (i == 20));
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL sat_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL sat_b[%0d]: got %h exp %h", i, gb, eb); end
        end
        tests++;
        if (bua !== 4'd0) begin failed++; $display("FAIL sat_clr: got %0d exp 0", bua); end
    endtask

    task automatic test_last_stage();
        outs_t ea, eb, ga, gb;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            step((i == 0) ? 6'b000000 : 6'b100000, 0, 1, (i == 0) ? 32'hA5 : 32'h77, 16'hBEEF, 2'd1, 0);
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL last_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL last_b[%0d]: got %h exp %h", i, gb, eb); end
        end
        tests++;
        if (vb !== 0 || db !== 32'hA5 || bub_b !== 4'd1 || hob !== 4'd0 || tb_t !== 16'hBEEF) begin
            failed++; $display("FAIL last_fix: got v=%b d=%h b=%0d h=%0d t=%h exp v=0 d=a5 b=1 h=0 t=beef", vb, db, bub_b, hob, tb_t);
        end
    endtask

    task automatic test_async_reset();
        outs_t ea, eb, ga, gb;
        apply_reset();
        step(6'b000000, 0, 1, 32'h33, 16'h0, 2'd0, 0);
        step(6'b011000, 0, 0, 32'h0, 16'h4321, 2'd1, 0);
        step(6'b011000, 0, 0, 32'h0, 16'h4321, 2'd1, 0);
        sb_a.delete(); sb_b.delete();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (snap_a() !== '0 || snap_b() !== '0) begin
            failed++; $display("FAIL async_rst: got a=%h b=%h exp 0", snap_a(), snap_b());
        end
        ma = '0; mb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(6'b011000, 0, 1, 32'h44, 16'h0101, 2'd3, 0);
        ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
        tests++;
        if (ga !== ea || va !== 1'b0 || hoa !== 4'd1) begin
            failed++; $display("FAIL rst_release_a: got %h exp %h", ga, ea);
        end
        tests++;
        if (gb !== eb) begin failed++; $display("FAIL rst_release_b: got %h exp %h", gb, eb); end
    endtask

    task automatic test_back_to_back();
        outs_t ea, eb, ga, gb;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            step(6'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom), $urandom,
                 16'($urandom), 2'($urandom), ($urandom_range(0, 24) == 0));
            ea = sb_a.pop_front(); eb = sb_b.pop_front(); ga = snap_a(); gb = snap_b();
            tests++;
            if (ga !== ea) begin failed++; $display("FAIL rand_a[%0d]: got %h exp %h", i, ga, ea); end
            tests++;
            if (gb !== eb) begin failed++; $display("FAIL rand_b[%0d]: got %h exp %h", i, gb, eb); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_advance_bubble();
        test_hold_loopback();
        test_flush();
        test_saturation();
        test_last_stage();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register, the generalised successor to the fixed EX/MEM latch. It carries an opaque payload plus a valid bit across one stage boundary, with the following behaviours:
- bubble insertion, hold and advance decided from the global stall vector;
- an exception flush with top priority;
- multi-cycle operation state feedback (temp/count loop-back);
- saturating bubble/hold performance counters;
- a consecutive-hold watchdog.

One instance sits at each of IF/ID, ID/EX, EX/MEM and MEM/WB, selected by `STAGE`.

## Interface
Parameters:
- `N_DATA`, 128, payload width (write data, address, aluop, cp0 fields, …; packed by the instantiating stage).
- `N_STALL`, 6, width of the stall vector.
- `STAGE`, 3, index of the upstream stage in `i_stall`; valid range 0..`N_STALL`-1.
- `N_TEMP`, 64, multi-cycle temp-state width (e.g. hilo_temp).
- `N_CNT`, 2, multi-cycle step-counter width.
- `ZERO_ON_BUBBLE`, 1. When 1, the payload is zeroed on a bubble. When 0, the payload is held and only valid drops.
- `N_PERF`, 16, performance-counter width.
- `HOLD_LIMIT`, 255, consecutive-hold count that raises the watchdog; range 1..2^`N_PERF`-1.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous reset, active-low.
- `i_stall` in `N_STALL`: global stall vector, 1 = STOP.
- `i_flush` in 1: exception/redirect flush.
- `i_valid` in 1: upstream instruction valid.
- `i_data` in `N_DATA`: upstream payload.
- `i_temp` in `N_TEMP`: upstream multi-cycle temp state.
- `i_cnt` in `N_CNT`: upstream multi-cycle step count.
- `i_perf_clr` in 1: synchronous clear of the performance counters.
- `o_valid` out 1: downstream valid.
- `o_data` out `N_DATA`: downstream payload.
- `o_temp` out `N_TEMP`: temp state fed back to the upstream stage.
- `o_cnt` out `N_CNT`: step count fed back to the upstream stage.
- `o_bubble_cnt` out `N_PERF`: bubbles inserted (saturating).
- `o_hold_cnt` out `N_PERF`: hold cycles (saturating).
- `o_hold_run` out `N_PERF`: current consecutive-hold run length.
- `o_hold_timeout` out 1: watchdog, sticky until a non-hold cycle.

## Operation
Definitions:
- `up` = `i_stall[STAGE]`.
- `dn` = `i_stall[STAGE+1]`; `dn` = 0 when `STAGE` = `N_STALL`-1.

Each cycle selects exactly one action, in strict priority order:
- **FLUSH** (`i_flush` = 1): `o_valid`←0, `o_data`←0, `o_temp`←0, `o_cnt`←0.
- **BUBBLE** (`up`=1, `dn`=0):
  - `o_valid`←0;
  - `o_data`←0 if `ZERO_ON_BUBBLE`, otherwise held;
  - `o_temp`←`i_temp`, `o_cnt`←`i_cnt`, so the stalled multi-cycle unit gets its state back.
- **ADVANCE** (`up`=0): `o_valid`←`i_valid`, `o_data`←`i_data`, `o_temp`←0, `o_cnt`←0.
- **HOLD** (`up`=1, `dn`=1): `o_valid` and `o_data` held; `o_temp`←`i_temp`, `o_cnt`←`i_cnt`.

Performance counters and watchdog:
- `o_bubble_cnt` increments on each BUBBLE; `o_hold_cnt` increments on each HOLD. Both saturate at all-ones and never wrap.
- `i_perf_clr` zeroes both counters and wins over a same-cycle increment: the result is 0, not 1.
- FLUSH does not clear the counters. A FLUSH while `up`=1 counts as neither bubble nor hold.
- `o_hold_run` increments on HOLD (saturating) and clears to 0 on any other action. `i_perf_clr` does not affect it.
- `o_hold_timeout` is 1 whenever the post-update `o_hold_run` ≥ `HOLD_LIMIT` (registered). It therefore falls in the cycle after the first non-hold action.

Reset values (asynchronous, while `i_rst_n`=0): every output is 0, so `o_valid`=0 and all counters are 0.

## Timing
- One-cycle latency: `i_*` sampled at edge N appear on `o_*` after edge N. There are no combinational input-to-output paths.
- The temp/cnt loop-back takes one cycle. The upstream stage sees its own state from edge N at N+1 while it is stalled.
- `i_flush` asserted at the same edge as `up`=0 with `i_valid`=1: the flush wins, `o_valid`=0, and the instruction is lost by design.
- Reset deassertion mid-stall: the first edge after release evaluates normally from the all-zero state. A HOLD in that edge keeps `o_valid`=0.
- `o_hold_run` exactly at `HOLD_LIMIT`: `o_hold_timeout` rises at that same registered update. For example, with `HOLD_LIMIT`=3 it is high after the third consecutive HOLD edge.

## Test plan
- **Advance then bubble.** `STAGE`=3. Edge 1: `i_stall`=000000, `i_valid`=1, `i_data`=0xA5. Edge 2: `i_stall`=001000.
  - After edge 1: `o_valid`=1, `o_data`=0xA5.
  - After edge 2: `o_valid`=0, `o_data`=0, `o_bubble_cnt`=1.
  - With `ZERO_ON_BUBBLE`=0, `o_data` stays 0xA5.
- **Hold and loop-back.** `o_valid`=1, `o_data`=0x11; then 3 cycles of `i_stall`=011000 with `i_temp`=0x1234, `i_cnt`=2.
  - `o_data` stays 0x11 and `o_valid` stays 1.
  - `o_temp`=0x1234, `o_cnt`=2 throughout.
  - `o_hold_cnt`=3.
  - With `HOLD_LIMIT`=3: `o_hold_timeout`=1 after the 3rd edge, then 0 one edge after `i_stall`=000000.
- **Flush priority.** `i_flush`=1 with `i_stall`=000000, `i_valid`=1, `i_data`=0xFF → `o_valid`=0, `o_data`=0, `o_temp`=0, and the counters are unchanged.
- **Saturation and clear.** With `N_PERF`=4, apply 20 bubbles → `o_bubble_cnt`=15. Then assert `i_perf_clr` together with a bubble → `o_bubble_cnt`=0.
- **Last stage.** `STAGE`=5, `i_stall`=100000 → BUBBLE (`dn` is treated as 0): `o_valid`=0, `o_bubble_cnt`=1.
- **Async reset mid-hold.** Assert `i_rst_n`=0 between edges → all outputs become 0 immediately, without waiting for a clock edge.
